serial_subtractor: RTL and testbench

Bit-serial unsigned/two's-complement subtractor, the inverse-direction companion to the combinational adder datapath. It accepts two WIDTH-bit operands and a borrow-in on a start strobe, then computes a − b − bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. Results are presented with a one-cycle done pulse and held until the next completion. It targets small arithmetic exercises where area matters more than latency.

---
 rtl/serial_subtractor_pkg.sv | 16 +
 rtl/serial_subtractor_full_sub.sv | 13 +
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that sizes the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter only ever holds 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Single-bit full subtractor: d = x - y - bi, with the borrow produced by that bit.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through one full-subtractor cell and a registered borrow.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    import serial_subtractor_pkg::*;

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, diff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q, a_msb_q, b_msb_q;
    logic               busy_q, done_q, bout_q, ovf_q;

    logic               cell_d, cell_bo;
    logic [WIDTH-1:0]   res_d;

    full_subtractor u_cell (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (borrow_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // NOTE: always_comb assigns every output unconditionally so no latch is inferred.
    always_comb begin
        res_d = {cell_d, res_q[WIDTH-1:1]};
    end

    // NOTE: every state register uses non-blocking assignment so all flops
    // see the pre-edge values of each other, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        a_msb_q  <= a[WIDTH-1];
                        b_msb_q  <= b[WIDTH-1];
                        res_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= cell_bo;
                    if (cnt_q == LAST) begin
                        // Last bit is resolved on this edge, so publish from res_d/cell_bo.
                        diff_q  <= res_d;
                        bout_q  <= cell_bo;
                        ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=8: drivers push
// expected results, per-instance monitors pop and compare on each done pulse.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic       clk, rst;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;
    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t m4, m8;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: plain integer subtraction reduced to w bits.
    task automatic model(input int w, input int av, input int bv, input int biv,
                         output logic [7:0] d, output logic bo, output logic ov);
        int r;
        r  = (av - bv - biv) & ((1 << w) - 1);
        d  = r[7:0];
        bo = (av < bv + biv);
        ov = (av[w-1] != bv[w-1]) && (r[w-1] != av[w-1]);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where the next op may be driven.
    task automatic run_op(input int w, input int av, input int bv, input int biv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        if (w == 4) begin
            a4 = av[3:0]; b4 = bv[3:0]; bin4 = biv[0]; start4 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; bin8 = biv[0]; start8 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        e.diff = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + w;
        if (w == 4) begin
            q4.push_back(e);
            check("w4_busy_after_start", int'(busy4), 1);
        end else begin
            q8.push_back(e);
            check("w8_busy_after_start", int'(busy8), 1);
        end
        repeat (w + 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                check("w4_done_expected", q4.size(), 1);
            end else begin
                m4 = q4.pop_front();
                check("w4_diff",    int'(diff4), int'(m4.diff[3:0]));
                check("w4_bout",    int'(bout4), int'(m4.bout));
                check("w4_ovf",     int'(ovf4),  int'(m4.ovf));
                check("w4_latency", cyc, m4.cyc);
                check("w4_busy_low_at_done", int'(busy4), 0);
            end
        end
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                check("w8_done_expected", q8.size(), 1);
            end else begin
                m8 = q8.pop_front();
                check("w8_diff",    int'(diff8), int'(m8.diff));
                check("w8_bout",    int'(bout8), int'(m8.bout));
                check("w8_ovf",     int'(ovf8),  int'(m8.ovf));
                check("w8_latency", cyc, m8.cyc);
                check("w8_busy_low_at_done", int'(busy8), 0);
            end
        end
    end

    initial begin
        logic [7:0] ed;
        logic       eb, eo;

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy4", int'(busy4), 0);
        check("rst_done4", int'(done4), 0);
        check("rst_diff4", int'(diff4), 0);
        check("rst_bout4", int'(bout4), 0);
        check("rst_ovf4",  int'(ovf4),  0);
        check("rst_busy8", int'(busy8), 0);
        check("rst_diff8", int'(diff8), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed 4-bit vectors. 9 is -7 signed, so -7 - 3 = -10 overflows.
        run_op(4,  9, 3, 0, 8'h6, 1'b0, 1'b1);
        run_op(4,  3, 9, 0, 8'hA, 1'b1, 1'b1);
        run_op(4, 15, 15, 0, 8'h0, 1'b0, 1'b0);
        run_op(4,  8, 1, 0, 8'h7, 1'b0, 1'b1);
        run_op(4,  0, 0, 1, 8'hF, 1'b1, 1'b0);

        // Abort two cycles into RUN: outputs clear and no done appears.
        a4 = 4'd1; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_diff", int'(diff4), 0);
        check("abort_bout", int'(bout4), 0);
        check("abort_ovf",  int'(ovf4),  0);
        check("abort_busy", int'(busy4), 0);
        check("abort_done", int'(done4), 0);
        repeat (8) @(negedge clk);
        run_op(4, 5, 2, 0, 8'h3, 1'b0, 1'b0);

        // start held high with operands changing every cycle: accepts every 6 edges.
        for (int i = 0; i < 18; i++) begin
            a4 = 4'((i * 3) + 1); b4 = 4'((i * 7) + 2); bin4 = i[0]; start4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if ((i % 6) == 0) begin
                exp_t e;
                model(4, (i * 3 + 1) & 15, (i * 7 + 2) & 15, i & 1, ed, eb, eo);
                e.diff = ed; e.bout = eb; e.ovf = eo; e.cyc = cyc + 4;
                q4.push_back(e);
            end
        end
        start4 = 1'b0;
        repeat (4) @(negedge clk);

        // Exhaustive 4-bit sweep.
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int biv = 0; biv < 2; biv++) begin
                    model(4, av, bv, biv, ed, eb, eo);
                    run_op(4, av, bv, biv, ed, eb, eo);
                end

        // 8-bit directed corners, then random operands.
        run_op(8, 8'h80, 8'h01, 0, 8'h7F, 1'b0, 1'b1);
        run_op(8, 8'h00, 8'hFF, 0, 8'h01, 1'b1, 1'b0);
        run_op(8, 8'hFF, 8'h00, 1, 8'hFE, 1'b0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            int av, bv, biv;
            av  = int'($urandom_range(255));
            bv  = int'($urandom_range(255));
            biv = int'($urandom_range(1));
            model(8, av, bv, biv, ed, eb, eo);
            run_op(8, av, bv, biv, ed, eb, eo);
        end

        for (int t = 0; t < 40 && (q4.size() != 0 || q8.size() != 0); t++) @(negedge clk);
        check("q4_drained", q4.size(), 0);
        check("q8_drained", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
